// File: rtl/vga_sync_module.sv
// rtl/vga_sync_module.sv - free-running VGA timing generator (sync, valid, X/Y, frame_start)
// Optional macro VGA_SYNC_ALIGN_EN delays valid/HS/VS/frame_start one cycle behind X/Y.
module vga_sync_module #(
  parameter int P_WIDTH = 10,
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0
) (
  input  logic               VGA_CLK,
  input  logic               RST_N,
  output logic [P_WIDTH-1:0] X,
  output logic [P_WIDTH-1:0] Y,
  output logic               valid,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [P_WIDTH-1:0] H_LAST    = P_WIDTH'(H_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] V_LAST    = P_WIDTH'(V_TOTAL - 1);
  localparam logic [P_WIDTH-1:0] H_ACT_C   = P_WIDTH'(H_ACT);
  localparam logic [P_WIDTH-1:0] V_ACT_C   = P_WIDTH'(V_ACT);
  localparam logic [P_WIDTH-1:0] H_SYNC_S  = P_WIDTH'(H_ACT + H_FP);
  localparam logic [P_WIDTH-1:0] H_SYNC_E  = P_WIDTH'(H_ACT + H_FP + H_SYNC);
  localparam logic [P_WIDTH-1:0] V_SYNC_S  = P_WIDTH'(V_ACT + V_FP);
  localparam logic [P_WIDTH-1:0] V_SYNC_E  = P_WIDTH'(V_ACT + V_FP + V_SYNC);

  logic [P_WIDTH-1:0] hc_q, hc_d;
  logic [P_WIDTH-1:0] vc_q, vc_d;
  logic               started_q;
  logic               valid_q, valid_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               fs_q, fs_d;

  // The first edge out of reset presents (0,0) rather than advancing, so
  // the counters hold until started_q is set.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (started_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Decoding the next-state counters keeps every registered output coherent with X/Y.
  always_comb begin
    valid_d = (hc_d < H_ACT_C) && (vc_d < V_ACT_C);
    hs_d    = ((hc_d >= H_SYNC_S) && (hc_d < H_SYNC_E)) ? H_POL : ~H_POL;
    vs_d    = ((vc_d >= V_SYNC_S) && (vc_d < V_SYNC_E)) ? V_POL : ~V_POL;
    fs_d    = (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      hc_q      <= '0;
      vc_q      <= '0;
      started_q <= 1'b0;
      valid_q   <= 1'b0;
      hs_q      <= ~H_POL;
      vs_q      <= ~V_POL;
      fs_q      <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      started_q <= 1'b1;
      valid_q   <= valid_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
    end
  end

  assign X = hc_q;
  assign Y = vc_q;

`ifdef VGA_SYNC_ALIGN_EN
  logic valid_a_q, hs_a_q, vs_a_q, fs_a_q;

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_a_q <= 1'b0;
      hs_a_q    <= ~H_POL;
      vs_a_q    <= ~V_POL;
      fs_a_q    <= 1'b0;
    end else begin
      valid_a_q <= valid_q;
      hs_a_q    <= hs_q;
      vs_a_q    <= vs_q;
      fs_a_q    <= fs_q;
    end
  end

  assign valid       = valid_a_q;
  assign VGA_HS      = hs_a_q;
  assign VGA_VS      = vs_a_q;
  assign frame_start = fs_a_q;
`else
  assign valid       = valid_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_vga_sync_module.sv
// tb/tb_vga_sync_module.sv - scoreboard bench for vga_sync_module (default and reduced geometry)
// Expected values come from cycle-count arithmetic; honours VGA_SYNC_ALIGN_EN.
module tb_vga_sync_module;

`ifdef VGA_SYNC_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  localparam int S_HA = 40, S_HF = 4, S_HS = 8, S_HB = 6;
  localparam int S_VA = 30, S_VF = 3, S_VS = 2, S_VB = 5;

  typedef struct {
    int ha, hf, hsync, hb, va, vf, vsync, vb;
    bit hp, vp;
  } geo_t;

  typedef struct {
    logic [9:0] x, y;
    logic valid, hs, vs, fs;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] xa, ya, xb, yb;
  logic       va, hsa, vsa, fsa;
  logic       vb, hsb, vsb, fsb;

  int    checks = 0;
  int    failures = 0;
  bit    done = 1'b0;
  pair_t q[$];
  geo_t  ga, gb;

  always #5 clk = ~clk;

  vga_sync_module u_a (
    .VGA_CLK(clk), .RST_N(rst_n), .X(xa), .Y(ya), .valid(va),
    .VGA_HS(hsa), .VGA_VS(vsa), .frame_start(fsa)
  );

  vga_sync_module #(
    .P_WIDTH(10), .H_ACT(S_HA), .V_ACT(S_VA),
    .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_b (
    .VGA_CLK(clk), .RST_N(rst_n), .X(xb), .Y(yb), .valid(vb),
    .VGA_HS(hsb), .VGA_VS(vsb), .frame_start(fsb)
  );

  function automatic exp_t reset_exp(geo_t g);
    exp_t e;
    e.x = '0; e.y = '0; e.valid = 1'b0;
    e.hs = !g.hp; e.vs = !g.vp; e.fs = 1'b0;
    return e;
  endfunction

  // k = number of rising edges seen since reset release, starting at 0.
  function automatic exp_t model(geo_t g, int k);
    exp_t e;
    int ht, vt, kd, px, py;
    ht = g.ha + g.hf + g.hsync + g.hb;
    vt = g.va + g.vf + g.vsync + g.vb;
    e = reset_exp(g);
    e.x = 10'(k % ht);
    e.y = 10'((k / ht) % vt);
    kd = ALIGN ? k - 1 : k;
    if (kd >= 0) begin
      px = kd % ht;
      py = (kd / ht) % vt;
      e.valid = (px < g.ha) && (py < g.va);
      e.hs = (px >= g.ha + g.hf && px < g.ha + g.hf + g.hsync) ? g.hp : !g.hp;
      e.vs = (py >= g.va + g.vf && py < g.va + g.vf + g.vsync) ? g.vp : !g.vp;
      e.fs = (px == 0) && (py == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_a(input exp_t e);
    chk("A.X", int'(xa), int'(e.x));
    chk("A.Y", int'(ya), int'(e.y));
    chk("A.valid", int'(va), int'(e.valid));
    chk("A.HS", int'(hsa), int'(e.hs));
    chk("A.VS", int'(vsa), int'(e.vs));
    chk("A.frame_start", int'(fsa), int'(e.fs));
  endtask

  task automatic check_b(input exp_t e);
    chk("B.X", int'(xb), int'(e.x));
    chk("B.Y", int'(yb), int'(e.y));
    chk("B.valid", int'(vb), int'(e.valid));
    chk("B.HS", int'(hsb), int'(e.hs));
    chk("B.VS", int'(vsb), int'(e.vs));
    chk("B.frame_start", int'(fsb), int'(e.fs));
  endtask

  task automatic push_reset();
    pair_t p;
    p.a = reset_exp(ga);
    p.b = reset_exp(gb);
    q.push_back(p);
  endtask

  initial begin
    int run_len;
    int rst_len;
    pair_t p;
    ga = '{ha:640, hf:16, hsync:96, hb:48, va:480, vf:10, vsync:2, vb:33, hp:1'b0, vp:1'b0};
    gb = '{ha:S_HA, hf:S_HF, hsync:S_HS, hb:S_HB, va:S_VA, vf:S_VF, vsync:S_VS, vb:S_VB,
           hp:1'b1, vp:1'b1};
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk);
      push_reset();
    end
    for (int seg = 0; seg < 4; seg++) begin
      run_len = (seg == 0) ? 5000 : int'($urandom_range(2500, 50));
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < run_len; k++) begin
        @(posedge clk);
        p.a = model(ga, k);
        p.b = model(gb, k);
        q.push_back(p);
      end
      // Reset asserted between edges must clear outputs before the next edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_a(reset_exp(ga));
      check_b(reset_exp(gb));
      rst_len = int'($urandom_range(4, 1));
      repeat (rst_len) begin
        @(posedge clk);
        push_reset();
      end
    end
    @(negedge clk);
    done = 1'b1;
  end

  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        p = q.pop_front();
        check_a(p.a);
        check_b(p.b);
      end else if (done) begin
        break;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
